// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state and owner encodings shared by the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;
  // slave: the arbiter itself; master: pipeline stages plus memory
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, busy
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_streak_cnt.sv
// mem_port_arbiter_streak_cnt: saturating count of consecutive D grants, with clear
module mem_port_arbiter_streak_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  localparam int CW = $clog2(MAX + 1);
  logic [CW-1:0] count_q, count_d;
  assign sat_o = count_q >= CW'(MAX);
  always_comb count_d = clr_i ? '0 : (inc_i && !sat_o) ? count_q + CW'(1) : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and data access
// with D priority and a streak limit that guarantees fetch progress.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              m_req_q, m_req_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              busy_q, busy_d;
  logic              grant_d, inc, clr, sat;

  mem_port_arbiter_streak_cnt #(.MAX(MAX_STREAK)) u_streak (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc),
    .clr_i (clr),
    .sat_o (sat)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    inc       = 1'b0;
    clr       = 1'b0;
    grant_d   = bus.d_req && (!bus.i_req || !sat);
    case (state_q)
      ST_IDLE: begin
        inc = grant_d && bus.i_req;
        clr = !inc;
        if (grant_d || bus.i_req) begin
          state_d   = ST_BUSY;
          owner_d   = grant_d ? OWNER_D : OWNER_I;
          m_we_d    = grant_d && bus.d_we;
          m_addr_d  = grant_d ? bus.d_addr : bus.i_addr;
          m_wdata_d = grant_d ? bus.d_wdata : '0;
        end
      end
      ST_BUSY: begin
        if (bus.m_ack) begin
          state_d   = ST_RESP;
          d_rdata_d = (owner_q == OWNER_D) ? bus.m_rdata : d_rdata_q;
          i_rdata_d = (owner_q == OWNER_I) ? bus.m_rdata : i_rdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // outputs are decoded from next state so they come straight out of flops
    m_req_d   = state_d == ST_BUSY;
    busy_d    = state_d != ST_IDLE;
    i_ready_d = state_d == ST_RESP && owner_d == OWNER_I;
    d_ready_d = state_d == ST_RESP && owner_d == OWNER_D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_I;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_req_q   <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_req_q   <= m_req_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, streak limit and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_ack = 0; bus.m_rdata = '0;
    #1;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_ready", {bus.i_ready, bus.d_ready}, 0);
    chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    tick; tick;
    rst = 1'b0;
    // lone fetch, ack two cycles after m_req
    bus.i_req = 1; bus.i_addr = 32'h0040_0000;
    tick;
    chk("f_m_req", bus.m_req, 1);
    chk("f_m_we", bus.m_we, 0);
    chk("f_m_addr", bus.m_addr, 32'h0040_0000);
    chk("f_busy", bus.busy, 1);
    tick;
    chk("f_wait", {bus.m_req, bus.i_ready}, 2'b10);
    bus.m_ack = 1; bus.m_rdata = 32'h2008_0005;
    tick;
    bus.m_ack = 0; bus.i_req = 0;
    chk("f_i_ready", bus.i_ready, 1);
    chk("f_i_rdata", bus.i_rdata, 32'h2008_0005);
    chk("f_d_ready", bus.d_ready, 0);
    chk("f_m_req_drop", bus.m_req, 0);
    tick;
    chk("f_pulse_end", bus.i_ready, 0);
    chk("f_idle", bus.busy, 0);
    // store with zero-wait ack
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
    tick;
    chk("s_m_we", bus.m_we, 1);
    chk("s_m_addr", bus.m_addr, 32'h10);
    chk("s_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    bus.m_ack = 1;
    tick;
    bus.m_ack = 0; bus.d_req = 0; bus.d_we = 0;
    chk("s_d_ready", bus.d_ready, 1);
    chk("s_i_ready", bus.i_ready, 0);
    tick;
    chk("s_pulse_end", {bus.d_ready, bus.busy}, 0);
    // contention: D wins until the streak saturates, then one fetch
    bus.i_req = 1; bus.i_addr = 32'h100; bus.d_req = 1; bus.d_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk($sformatf("c%0d_addr", k), bus.m_addr, exp_d[k] ? 32'h200 : 32'h100);
      bus.m_ack = 1; bus.m_rdata = 32'h1000 + k;
      tick;
      bus.m_ack = 0;
      chk($sformatf("c%0d_ready", k), {bus.i_ready, bus.d_ready}, exp_d[k] ? 2'b01 : 2'b10);
      chk($sformatf("c%0d_rdata", k), exp_d[k] ? bus.d_rdata : bus.i_rdata, 32'h1000 + k);
      tick;
      chk($sformatf("c%0d_idle", k), bus.busy, 0);
    end
    bus.i_req = 0; bus.d_req = 0;
    tick;
    // async reset while BUSY, request held across it
    bus.d_req = 1; bus.d_addr = 32'h300;
    tick;
    chk("r_m_req_pre", bus.m_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_m_req_async", bus.m_req, 0);
    chk("r_busy_async", bus.busy, 0);
    chk("r_ready_async", {bus.i_ready, bus.d_ready}, 0);
    chk("r_m_addr_async", bus.m_addr, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("r_regrant", {bus.m_req, bus.m_addr}, {1'b1, 32'h300});
    bus.m_ack = 1; bus.m_rdata = 32'h55;
    tick;
    bus.m_ack = 0; bus.d_req = 0;
    chk("r_d_ready", {bus.d_ready, bus.d_rdata}, {1'b1, 32'h55});
    tick;
    // spurious acks in IDLE and RESP
    bus.m_ack = 1; bus.m_rdata = 32'h77;
    tick;
    chk("sp_idle", {bus.busy, bus.m_req, bus.i_ready, bus.d_ready}, 0);
    bus.m_ack = 0; bus.d_req = 1; bus.d_addr = 32'h400;
    tick;
    bus.m_ack = 1; bus.m_rdata = 32'hAAAA;
    tick;
    bus.d_req = 0; bus.m_rdata = 32'hBBBB;
    chk("sp_resp_ready", bus.d_ready, 1);
    tick;
    bus.m_ack = 0;
    chk("sp_resp_state", {bus.busy, bus.m_req, bus.d_ready}, 0);
    chk("sp_resp_rdata", bus.d_rdata, 32'hAAAA);
    // d_req dropped mid-access; address change after grant has no effect
    bus.d_req = 1; bus.d_addr = 32'h500;
    tick;
    bus.d_req = 0; bus.d_addr = 32'h600;
    tick;
    chk("dr_hold", {bus.m_req, bus.m_addr}, {1'b1, 32'h500});
    bus.m_ack = 1; bus.m_rdata = 32'hC0DE;
    tick;
    bus.m_ack = 0;
    chk("dr_ready", {bus.d_ready, bus.d_rdata}, {1'b1, 32'hC0DE});
    tick;
    chk("dr_end", {bus.d_ready, bus.busy}, 0);
    tick;
    chk("dr_no_regrant", bus.m_req, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
